// File: rtl/mux_pkg.sv
// Shared mux constants, select encodings and helpers.
// Imported by the n-way mux and by stages that instantiate it.
package mux_pkg;

    // Policy for a select that does not name a real input
    localparam int MUX_OOR_LAST = 0;
    localparam int MUX_OOR_ZERO = 1;

    // ALU-operand select encodings
    localparam int SLC_RS        = 0;
    localparam int SLC_FWD_EXMEM = 1;
    localparam int SLC_FWD_MEMWB = 2;
    localparam int SLC_IMM       = 3;

    function automatic int mux_clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_mux_nway_sel.sv
// Combinational N-way select with out-of-range detection.
// Ports: in_flat (packed inputs), slc, sel_data, oor.
module mod_mux_nway_sel
    import mux_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_IN   = 8,
    parameter int SLC_W    = 3,
    parameter int OOR_MODE = MUX_OOR_LAST
) (
    input  logic [NUM_IN*WIDTH-1:0] in_flat,
    input  logic [SLC_W-1:0]        slc,
    output logic [WIDTH-1:0]        sel_data,
    output logic                    oor
);

    always_comb begin
        oor = (32'(slc) >= 32'(NUM_IN));
        // Out-of-range default; overridden by any matching input
        if (OOR_MODE == MUX_OOR_ZERO) begin
            sel_data = '0;
        end else begin
            sel_data = in_flat[(NUM_IN-1)*WIDTH +: WIDTH];
        end
        for (int k = 0; k < NUM_IN; k++) begin
            if (32'(slc) == 32'(k)) begin
                sel_data = in_flat[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mod_mux_pipe_nway.sv
// N-way operand mux with one registered output stage.
// Ports: clk, rst_n, in_flat, slc, in_valid, stall, flush,
//        out, out_valid, out_slc, oor_err.
module mod_mux_pipe_nway
    import mux_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_IN   = 8,
    parameter int SLC_W    = 3,
    parameter int OOR_MODE = MUX_OOR_LAST
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_flat,
    input  logic [SLC_W-1:0]        slc,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    output logic [SLC_W-1:0]        out_slc,
    output logic                    oor_err
);

    if (SLC_W < mux_clog2(NUM_IN)) begin : g_bad_slc_w
        $error("SLC_W too narrow for NUM_IN");
    end
    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("NUM_IN must be 2..16");
    end
    if (OOR_MODE != MUX_OOR_LAST && OOR_MODE != MUX_OOR_ZERO) begin : g_bad_mode
        $error("OOR_MODE must be 0 or 1");
    end

    logic [WIDTH-1:0] sel_data;
    logic             sel_oor;

    mod_mux_nway_sel #(
        .WIDTH    (WIDTH),
        .NUM_IN   (NUM_IN),
        .SLC_W    (SLC_W),
        .OOR_MODE (OOR_MODE)
    ) u_sel (
        .in_flat  (in_flat),
        .slc      (slc),
        .sel_data (sel_data),
        .oor      (sel_oor)
    );

    // flush > stall > load; bubbles keep out/out_slc steady
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_slc   <= '0;
            oor_err   <= 1'b0;
        end else if (flush) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_slc   <= '0;
            oor_err   <= 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                out       <= sel_data;
                out_valid <= 1'b1;
                out_slc   <= slc;
                oor_err   <= sel_oor;
            end else begin
                out_valid <= 1'b0;
                oor_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod_mux_pipe_nway.sv
// Bench for mod_mux_pipe_nway: four instances (8-way, 5-way x2
// policies, 2-way 5-bit) against a behavioural model.
module tb_mod_mux_pipe_nway;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] slc = '0;
    logic       in_valid = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;

    always #5 clk = ~clk;

    // Model view: input words and config per instance
    logic [31:0] words [4][16];
    int          n_in  [4] = '{8, 5, 5, 2};
    int          mode  [4] = '{0, 0, 1, 0};

    logic [255:0] in0;
    logic [159:0] in1;
    logic [159:0] in2;
    logic [9:0]   in3;

    always_comb begin
        in0 = '0;
        in1 = '0;
        in2 = '0;
        in3 = '0;
        for (int k = 0; k < 8; k++) in0[k*32 +: 32] = words[0][k];
        for (int k = 0; k < 5; k++) in1[k*32 +: 32] = words[1][k];
        for (int k = 0; k < 5; k++) in2[k*32 +: 32] = words[2][k];
        for (int k = 0; k < 2; k++) in3[k*5 +: 5]   = words[3][k][4:0];
    end

    logic [31:0] d0_out, d1_out, d2_out;
    logic [4:0]  d3_out;
    logic        d0_v, d1_v, d2_v, d3_v;
    logic [2:0]  d0_s, d1_s, d2_s;
    logic        d3_s;
    logic        d0_e, d1_e, d2_e, d3_e;

    mod_mux_pipe_nway #(.WIDTH(32), .NUM_IN(8), .SLC_W(3), .OOR_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_flat(in0), .slc(slc),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out(d0_out), .out_valid(d0_v), .out_slc(d0_s), .oor_err(d0_e));

    mod_mux_pipe_nway #(.WIDTH(32), .NUM_IN(5), .SLC_W(3), .OOR_MODE(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_flat(in1), .slc(slc),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out(d1_out), .out_valid(d1_v), .out_slc(d1_s), .oor_err(d1_e));

    mod_mux_pipe_nway #(.WIDTH(32), .NUM_IN(5), .SLC_W(3), .OOR_MODE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_flat(in2), .slc(slc),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out(d2_out), .out_valid(d2_v), .out_slc(d2_s), .oor_err(d2_e));

    mod_mux_pipe_nway #(.WIDTH(5), .NUM_IN(2), .SLC_W(1), .OOR_MODE(0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_flat(in3), .slc(slc[0]),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out(d3_out), .out_valid(d3_v), .out_slc(d3_s), .oor_err(d3_e));

    logic [31:0] o_out [4];
    logic        o_v   [4];
    logic [31:0] o_s   [4];
    logic        o_e   [4];

    always_comb begin
        o_out[0] = d0_out;         o_out[1] = d1_out;
        o_out[2] = d2_out;         o_out[3] = {27'd0, d3_out};
        o_v[0] = d0_v;  o_v[1] = d1_v;  o_v[2] = d2_v;  o_v[3] = d3_v;
        o_s[0] = {29'd0, d0_s};    o_s[1] = {29'd0, d1_s};
        o_s[2] = {29'd0, d2_s};    o_s[3] = {31'd0, d3_s};
        o_e[0] = d0_e;  o_e[1] = d1_e;  o_e[2] = d2_e;  o_e[3] = d3_e;
    end

    // Expected output registers
    logic [31:0] e_out [4];
    logic        e_v   [4];
    logic [31:0] e_s   [4];
    logic        e_e   [4];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_sel(input int d, input int s);
        if (s < n_in[d]) return words[d][s];
        if (mode[d] == 1) return 32'd0;
        return words[d][n_in[d]-1];
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 4; d++) begin
            e_out[d] = '0; e_v[d] = 1'b0; e_s[d] = '0; e_e[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int s;
        if (!rst_n || flush) begin
            model_clear();
        end else if (!stall) begin
            for (int d = 0; d < 4; d++) begin
                if (in_valid) begin
                    s = (d == 3) ? int'(slc[0]) : int'(slc);
                    e_out[d] = ref_sel(d, s);
                    e_s[d]   = 32'(s);
                    e_e[d]   = (s >= n_in[d]);
                    e_v[d]   = 1'b1;
                end else begin
                    e_v[d] = 1'b0;
                    e_e[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic cmp_all(input string ph);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s.out%0d", ph, d), o_out[d], e_out[d]);
            chk($sformatf("%s.vld%0d", ph, d), 32'(o_v[d]), 32'(e_v[d]));
            chk($sformatf("%s.slc%0d", ph, d), o_s[d], e_s[d]);
            chk($sformatf("%s.oor%0d", ph, d), 32'(o_e[d]), 32'(e_e[d]));
        end
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        cmp_all(ph);
    endtask

    task automatic drive(input logic v, input logic [2:0] s,
                         input logic st, input logic fl);
        in_valid = v;
        slc      = s;
        stall    = st;
        flush    = fl;
    endtask

    initial begin
        for (int d = 0; d < 4; d++)
            for (int k = 0; k < 16; k++) words[d][k] = '0;
        for (int k = 0; k < 8; k++) words[0][k] = 32'hA000_0000 + 32'(k);
        for (int k = 0; k < 5; k++) begin
            words[1][k] = 32'h1000_0000 + 32'(k);
            words[2][k] = 32'h1000_0000 + 32'(k);
        end
        words[1][4] = 32'h0000_BEEF;
        words[2][4] = 32'h0000_BEEF;
        words[3][0] = 32'h1F;
        words[3][1] = 32'h0A;
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        cmp_all("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep all legal selects on the 8-way instance
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'(k), 1'b0, 1'b0);
            step("sweep");
            chk("sweep.lit", d0_out, 32'hA000_0000 + 32'(k));
        end

        // Out-of-range on the 5-way instances, then a legal select
        drive(1'b1, 3'd6, 1'b0, 1'b0);
        step("oor");
        chk("oor.last", d1_out, 32'h0000_BEEF);
        chk("oor.zero", d2_out, 32'h0);
        chk("oor.err", 32'({d1_e, d2_e}), 32'h3);
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        step("oorclr");
        chk("oorclr.err", 32'({d1_e, d2_e}), 32'h0);

        // Stall holds, flush beats stall
        drive(1'b1, 3'd2, 1'b0, 1'b0);
        step("load2");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd5, 1'b1, 1'b0);
            step("stall");
            chk("stall.lit", d0_out, 32'hA000_0002);
        end
        drive(1'b1, 3'd5, 1'b1, 1'b1);
        step("flush");
        chk("flush.lit", 32'({d0_v, 1'b0}) | d0_out, 32'h0);

        // Bubble with an unknown select
        drive(1'b1, 3'd3, 1'b0, 1'b0);
        step("load3");
        drive(1'b0, 3'bxxx, 1'b0, 1'b0);
        step("bubble");
        chk("bubble.lit", d0_out, 32'hA000_0003);
        chk("bubble.x", 32'($isunknown(d0_out)), 32'h0);

        // Async reset in mid-cycle
        drive(1'b1, 3'd4, 1'b0, 1'b0);
        step("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        cmp_all("arst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        step("post_rst");
        chk("post_rst.lit", d0_out, 32'hA000_0001);

        // Two-way alternation
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 3'(i & 1), 1'b0, 1'b0);
            step("alt");
            chk("alt.lit", 32'(d3_out), (i & 1) ? 32'h0A : 32'h1F);
        end

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) begin
                for (int d = 0; d < 3; d++)
                    for (int k = 0; k < n_in[d]; k++)
                        words[d][k] = $urandom;
                words[3][0] = 32'($urandom_range(31));
                words[3][1] = 32'($urandom_range(31));
            end
            drive($urandom_range(3) != 0, 3'($urandom_range(7)),
                  $urandom_range(3) == 0, $urandom_range(7) == 0);
            if (!in_valid && $urandom_range(1) == 1) slc = 3'bxxx;
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
